// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and defaults for the CPU clock-enable controller.
package cpu_clk_ctrl_pkg;

  localparam int DIV_W_DEFAULT           = 32;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

  typedef enum logic [1:0] {
    S_STEP = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Width needed to hold a count of 0 .. cycles-1, never less than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_debouncer.sv
// Two-flop synchronizer followed by a stability-count debouncer for one raw board input.
module debouncer
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous input into the board clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has disagreed with the debounced one for a full window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stable_cnt <= '0;
      o_level    <= 1'b0;
    end else if (sync_q2 == o_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      o_level    <= sync_q2;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run / single-step tick generation with a sticky halt.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W           = DIV_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] i_divider,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic             i_halt,
  output logic             o_tick,
  output logic             o_clk,
  output logic             o_running
);

  logic             mode_db;
  logic             step_db;
  logic             step_db_q;
  logic             step_rise;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic             tick_d;
  state_t           state_q;
  state_t           state_d;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_mode),
    .o_level(mode_db)
  );

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_step),
    .o_level(step_db)
  );

  assign step_rise = step_db & ~step_db_q;

  // Divider values 0 and 1 both mean a tick every cycle; no latching, follows the switches live.
  assign div_eff = (i_divider == '0) ? DIV_W'(1) : i_divider;

  // Remember last cycle's debounced step so a press yields exactly one rising edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_db_q <= 1'b0;
    end else begin
      step_db_q <= step_db;
    end
  end

  // State, divider counter and the registered outputs all advance together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_STEP;
      count_q   <= '0;
      o_tick    <= 1'b0;
      o_clk     <= 1'b0;
      o_running <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      o_tick    <= tick_d;
      o_running <= (state_d == S_RUN);
      if (tick_d) begin
        o_clk <= ~o_clk;
      end
    end
  end

  // Next state and tick decision: halt first, then mode change, then step / divider tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    case (state_q)
      S_STEP: begin
        if (i_halt) begin
          state_d = S_HALT;
          count_d = '0;
        end else if (mode_db) begin
          state_d = S_RUN;
          count_d = '0;
        end else if (step_rise) begin
          tick_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_halt) begin
          state_d = S_HALT;
          count_d = '0;
        end else if (!mode_db) begin
          state_d = S_STEP;
          count_d = '0;
        end else if (count_q >= (div_eff - DIV_W'(1))) begin
          tick_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + DIV_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_STEP;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: directed scenarios plus randomized switch/button activity.
module tb_cpu_clk_ctrl;

  localparam int DIV_W = 32;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             step;
  logic             halt;
  logic [DIV_W-1:0] divider;
  logic             tick;
  logic             clk_led;
  logic             running;

  cpu_clk_ctrl #(
    .DIV_W          (DIV_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_divider(divider),
    .i_mode   (mode),
    .i_step   (step),
    .i_halt   (halt),
    .o_tick   (tick),
    .o_clk    (clk_led),
    .o_running(running)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int cyc;
    bit led;
  } exp_tick_t;

  exp_tick_t exp_q[$];

  // Reference model state (behavioural, cycle counted by edges).
  int cyc       = 0;
  bit hist_m[$];
  bit hist_s[$];
  bit deb_m     = 1'b0;
  bit deb_s     = 1'b0;
  bit deb_s_old = 1'b0;
  int streak_m  = 0;
  int streak_s  = 0;
  bit m_running = 1'b0;
  bit m_halted  = 1'b0;
  int m_since   = 0;
  bit m_led     = 1'b0;

  // Observation bookkeeping used by the directed scenarios.
  int tick_cnt = 0;
  int obs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit m, input bit s, input bit h, input int d);
    mode    = m;
    step    = s;
    halt    = h;
    divider = DIV_W'(d);
  endtask

  // Model: decide this edge's outcome from pre-edge conditioned inputs, then update conditioning.
  always @(posedge clk) begin
    int        div;
    bit        rise;
    bit        s_m;
    bit        s_s;
    bit        fire;
    exp_tick_t e;
    cyc++;
    fire = 1'b0;
    if (rst) begin
      hist_m.delete();
      hist_s.delete();
      hist_m.push_back(1'b0);
      hist_m.push_back(1'b0);
      hist_s.push_back(1'b0);
      hist_s.push_back(1'b0);
      deb_m     = 1'b0;
      deb_s     = 1'b0;
      deb_s_old = 1'b0;
      streak_m  = 0;
      streak_s  = 0;
      m_running = 1'b0;
      m_halted  = 1'b0;
      m_since   = 0;
      m_led     = 1'b0;
    end else begin
      div  = (divider == 0) ? 1 : int'(divider);
      rise = deb_s && !deb_s_old;
      if (m_halted) begin
        fire = 1'b0;
      end else if (halt) begin
        m_halted  = 1'b1;
        m_running = 1'b0;
      end else if (!m_running) begin
        if (deb_m) begin
          m_running = 1'b1;
          m_since   = 0;
        end else if (rise) begin
          fire = 1'b1;
        end
      end else if (!deb_m) begin
        m_running = 1'b0;
      end else begin
        m_since++;
        if (m_since >= div) begin
          fire    = 1'b1;
          m_since = 0;
        end
      end
      if (fire) begin
        m_led = !m_led;
        e.cyc = cyc;
        e.led = m_led;
        exp_q.push_back(e);
      end
      deb_s_old = deb_s;
      s_m = hist_m.pop_front();
      hist_m.push_back(mode);
      s_s = hist_s.pop_front();
      hist_s.push_back(step);
      if (s_m != deb_m) begin
        streak_m++;
        if (streak_m == DEB) begin
          deb_m    = s_m;
          streak_m = 0;
        end
      end else begin
        streak_m = 0;
      end
      if (s_s != deb_s) begin
        streak_s++;
        if (streak_s == DEB) begin
          deb_s    = s_s;
          streak_s = 0;
        end
      end else begin
        streak_s = 0;
      end
    end
  end

  // Monitor: on the opposite edge, pop expected ticks and compare every output.
  always @(negedge clk) begin
    bit        exp_now;
    exp_tick_t e;
    exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (tick === 1'b1) begin
      tick_cnt++;
      obs.push_back(cyc);
    end
    checkOutput("o_tick", tick, exp_now);
    if (exp_now) begin
      e = exp_q.pop_front();
      checkOutput("o_clk_at_tick", clk_led, e.led);
    end
    checkOutput("o_running", running, m_running);
    checkOutput("o_clk", clk_led, m_led);
  end

  initial begin
    int base;
    bit found;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    cycles(3);
    rst = 1'b0;

    $display("[TB] reset idle");
    tick_cnt = 0;
    cycles(100);
    checkOutput("reset_ticks", tick_cnt, 0);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_clk", clk_led, 0);

    $display("[TB] single step");
    obs.delete();
    tick_cnt = 0;
    base     = cyc;
    step     = 1'b1;
    cycles(50);
    checkOutput("step_count", tick_cnt, 1);
    checkOutput("step_latency", (obs.size() > 0) ? obs[0] - base : -1, 7);
    checkOutput("step_led", clk_led, 1);
    step = 1'b0;
    cycles(20);
    tick_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step = ~step;
      cycles(2);
    end
    step = 1'b1;
    cycles(30);
    checkOutput("bounce_count", tick_cnt, 1);
    step = 1'b0;
    cycles(20);

    $display("[TB] run mode");
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    cycles(30);
    tick_cnt = 0;
    cycles(50);
    checkOutput("run5_count", tick_cnt, 10);
    checkOutput("run5_running", running, 1);
    divider = 0;
    cycles(3);
    tick_cnt = 0;
    cycles(20);
    checkOutput("run0_count", tick_cnt, 20);
    divider = 1;
    cycles(3);
    tick_cnt = 0;
    cycles(20);
    checkOutput("run1_count", tick_cnt, 20);

    $display("[TB] divider shrink");
    divider = 100;
    found   = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      cycles(1);
      if (tick === 1'b1) found = 1'b1;
    end
    checkOutput("shrink_sync", found, 1);
    cycles(60);
    obs.delete();
    base    = cyc;
    divider = 10;
    cycles(25);
    checkOutput("shrink_first", (obs.size() > 0) ? obs[0] - base : -1, 1);
    checkOutput("shrink_period", (obs.size() > 1) ? obs[1] - obs[0] : -1, 10);

    $display("[TB] halt");
    divider = 5;
    cycles(20);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      if (tick === 1'b1) found = 1'b1;
    end
    checkOutput("halt_sync", found, 1);
    cycles(4);
    halt = 1'b1;
    cycles(1);
    halt = 1'b0;
    checkOutput("halt_no_tick", tick, 0);
    checkOutput("halt_running", running, 0);
    tick_cnt = 0;
    cycles(200);
    checkOutput("halt_quiet", tick_cnt, 0);
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(20);
    mode = 1'b0;
    cycles(20);
    mode = 1'b1;
    cycles(20);
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(20);
    checkOutput("halt_ignores", tick_cnt, 0);
    checkOutput("halt_still", running, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    cycles(3);
    rst      = 1'b0;
    tick_cnt = 0;
    cycles(100);
    checkOutput("rereset_ticks", tick_cnt, 0);
    checkOutput("rereset_clk", clk_led, 0);
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(20);
    checkOutput("rereset_step", tick_cnt, 1);

    $display("[TB] mode/step collision");
    applyStimulus(1'b1, 1'b0, 1'b0, 1000);
    cycles(20);
    tick_cnt = 0;
    mode     = 1'b0;
    step     = 1'b1;
    cycles(30);
    checkOutput("collide_ticks", tick_cnt, 0);
    checkOutput("collide_running", running, 0);
    step = 1'b0;
    cycles(20);
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(20);
    checkOutput("collide_next_press", tick_cnt, 1);

    $display("[TB] randomized activity");
    for (int blk = 0; blk < 6; blk++) begin
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 39) == 0) mode = ~mode;
        if ($urandom_range(0, 9) == 0) step = ~step;
        if ($urandom_range(0, 49) == 0) divider = DIV_W'($urandom_range(0, 12));
        halt = ($urandom_range(0, 999) == 0);
        cycles(1);
      end
    end
    halt = 1'b0;
    cycles(5);
    checkOutput("pending_ticks", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

CPU clock-enable controller for the Mimas V2 top level, sitting directly upstream of `cpu`. It takes its run rate from the DIP-switch divider word, a run/step mode switch and a step pushbutton, and drives a single-cycle tick. The tick advances the CPU in free-run or single-step mode, and the CPU's halt request stops it. It replaces the free-running divided clock with a board-clock-domain enable, so the whole design stays on one clock.

## Interface

Parameters:
- `DIV_W`, default 32: width of the divider word.
- `DEBOUNCE_CYCLES`, default 100000: number of consecutive stable synchronized cycles before a debounced input changes (1 ms at 100 MHz).

Ports:
- `i_clk`, in, 1: board clock. This is the only clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_divider`, in, `DIV_W`: run-mode tick period in `i_clk` cycles. Values 0 and 1 both mean a tick every cycle.
- `i_mode`, in, 1: raw switch, asynchronous. 1 = run, 0 = step.
- `i_step`, in, 1: raw pushbutton, asynchronous, active-high.
- `i_halt`, in, 1: halt request from the CPU, synchronous to `i_clk`.
- `o_tick`, out, 1: registered one-cycle CPU clock-enable pulse.
- `o_clk`, out, 1: registered; toggles on every tick (clock-visualisation LED).
- `o_running`, out, 1: registered; 1 exactly when the state is S_RUN.

## Operation

Input conditioning:
- `i_mode` and `i_step` each pass through a 2-flop synchronizer, then a debouncer.
- The debounced value takes the synchronized value once that value has differed from the debounced value for `DEBOUNCE_CYCLES` consecutive cycles.
- Any return to the old value before then restarts the count.
- Debounced values reset to 0.
- `step_rise` = debounced step is 1 and was 0 in the previous cycle.

`div_eff` = max(`i_divider`, 1), evaluated every cycle with no latching.

FSM states:
- **S_STEP** (reset state).
  - Halt → S_HALT (halt check comes first).
  - Else debounced mode = 1 → S_RUN, counter cleared to 0.
  - Else `step_rise` → tick.
- **S_RUN**.
  - Halt → S_HALT.
  - Else debounced mode = 0 → S_STEP, counter cleared, no tick.
  - Else if counter ≥ `div_eff`−1 → tick and counter := 0.
  - Otherwise counter := counter+1.
- **S_HALT**: absorbing; no ticks. `step_rise` and mode changes are ignored. The only exit is `i_rst`.

Priorities and boundaries:
- `i_halt` beats a tick due in the same cycle.
- A mode change beats `step_rise` or a run tick in the same cycle.
- Shrinking `i_divider` below counter+1 forces a tick on the next evaluation (≥ compare). It never waits for the counter to wrap.
- The counter is `DIV_W` bits and never overflows, because it is reset at ≥ `div_eff`−1.
- Reset mid-count clears the counter, FSM, synchronizers, debouncers and all outputs.

Reset values: `o_tick`=0, `o_clk`=0, `o_running`=0, state S_STEP, counter 0.

## Timing

- All outputs are registered. "Tick" means `o_tick`=1 in the following cycle, with `o_clk` toggling on that same edge.
- Step latency, from raw `i_step` rising (bounce-free) to `o_tick`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. Exactly one pulse per press, regardless of hold time.
- Run mode: the first tick comes `div_eff` cycles after the transition into S_RUN. After that, the period is exactly `div_eff` cycles. With `div_eff`=1, `o_tick` is held high continuously.
- `o_running` follows the state register with the same one-cycle registration.
- `i_halt` is sampled in S_STEP and S_RUN: halt at cycle n suppresses any tick at n+1, and no ticks follow thereafter.

## Structure

- Package `cpu_clk_ctrl_pkg`:
  - `state_t` (2-bit: S_STEP=0, S_RUN=1, S_HALT=2).
  - Default constants for `DIV_W` and `DEBOUNCE_CYCLES`.
- Sub-module `debouncer`, parameterised by `DEBOUNCE_CYCLES`. It contains the 2-flop synchronizer, stability counter and debounced register, and is instantiated twice (mode, step).
- Top `cpu_clk_ctrl` holds the edge detector, FSM, divider counter and output registers.

## Test plan

Bench uses `DEBOUNCE_CYCLES`=4.

1. **Reset**: `i_rst` for 3 cycles, `i_mode`=0, `i_step`=0, 100 cycles → `o_tick`, `o_clk`, `o_running` stay 0.
2. **Single step**:
   - Mode 0, step raised cleanly and held 50 cycles → exactly one `o_tick`, 7 cycles after the raise, and `o_clk`=1.
   - Step toggled every 2 cycles for 12 cycles, then held high → exactly one tick.
3. **Run**:
   - Mode 1, `i_divider`=5 → `o_running`=1 and ticks every 5 cycles (10 ticks in 50 cycles); `o_clk` toggles per tick.
   - `i_divider`=0 or 1 → `o_tick` is continuously 1.
4. **Divider shrink**: `i_divider`=100, counter at 60, then set to 10 → tick on the next cycle, then period 10.
5. **Halt**:
   - Running, `i_halt` pulsed for 1 cycle in the cycle a tick is due → no tick, `o_running`=0, and no ticks for 200 cycles.
   - Step presses and mode toggles have no effect.
   - `i_rst` restores the scenario-1 behaviour.
6. **Mode/step collision**: debounced mode drops to 0 in the same cycle as `step_rise` → no tick, state S_STEP, counter 0. The next clean press → one tick.
